// File: rtl/usb_ep_status_mp_pkg.sv
// Shared types and helpers for the multi-port USB endpoint status store.
package usb_ep_status_mp_pkg;

    // Controller phases: wipe the status RAM, then serve requests forever.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ep_state_e;

    // Operation carried down the pipeline with an accepted request.
    // rd is set for both normal and zero reads; zero forces the returned word to 0.
    typedef struct packed {
        logic we;
        logic rd;
        logic zero;
    } ep_op_t;

    localparam ep_op_t OP_IDLE = '{we: 1'b0, rd: 1'b0, zero: 1'b0};

    // Ceiling log2 with a floor of one bit, so single-entry indices stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/usb_ep_status_mp_if.sv
// Request/response bundle between the requesters and the EP status store.
interface usb_ep_status_mp_if #(
    parameter int N_PORTS = 2,
    parameter int AW      = 9,
    parameter int DW      = 16
);
    logic [N_PORTS*AW-1:0] req_addr;
    logic [N_PORTS-1:0]    req_read;
    logic [N_PORTS-1:0]    req_zero;
    logic [N_PORTS-1:0]    req_write;
    logic [N_PORTS*DW-1:0] req_din;
    logic [N_PORTS-1:0]    req_ready;
    logic [N_PORTS*DW-1:0] rsp_dout;
    logic [N_PORTS-1:0]    rsp_valid;
    logic                  init_done;

    // Requester side
    modport master (
        output req_addr, req_read, req_zero, req_write, req_din,
        input  req_ready, rsp_dout, rsp_valid, init_done
    );

    // Status store side
    modport slave (
        input  req_addr, req_read, req_zero, req_write, req_din,
        output req_ready, rsp_dout, rsp_valid, init_done
    );
endinterface

// File: rtl/usb_ep_status_mp_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant; the pointer advances past the
// winner only on cycles where a grant is actually issued.
module usb_rr_arbiter
    import usb_ep_status_mp_pkg::*;
#(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = clog2_min1(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    // Search from the pointer with wrap; first requester found wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!en) begin
            gnt   = '0;
            ptr_d = ptr_q;
        end
    end

    // Pointer register; after reset the lowest entry has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/usb_ep_status_mp.sv
// Multi-port USB endpoint status store: port 0 has absolute priority, the
// other ports share round-robin, one request per cycle into a single-port RAM.
// After reset the RAM is wiped to zero before any request is accepted.
module usb_ep_status_mp
    import usb_ep_status_mp_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int AW      = 9,
    parameter int DW      = 16
) (
    input logic                clk,
    input logic                rst,
    usb_ep_status_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = clog2_min1(N_PORTS);
    localparam int NA    = N_PORTS - 1;

    ep_state_e          state_q;
    logic [AW-1:0]      clr_cnt_q;
    logic               init_done_q;

    logic [N_PORTS-1:0] requesting;
    logic [N_PORTS-1:0] ready;
    logic [NA-1:0]      arb_gnt;
    logic               arb_en;
    logic               run;
    logic [PW-1:0]      acc_port;

    logic               vld_p1_d, vld_p1_q;
    logic [AW-1:0]      addr_p1_d, addr_p1_q;
    logic [DW-1:0]      din_p1_d, din_p1_q;
    ep_op_t             op_p1_d, op_p1_q;
    logic [PW-1:0]      port_p1_d, port_p1_q;

    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      mem [DEPTH];

    logic               vld_p2_d, vld_p2_q;
    logic [DW-1:0]      data_p2_q;
    logic               zero_p2_d, zero_p2_q;
    logic [PW-1:0]      port_p2_d, port_p2_q;

    logic [N_PORTS-1:0]    rsp_valid_d, rsp_valid_q;
    logic [N_PORTS*DW-1:0] rsp_dout_d, rsp_dout_q;

    assign run        = (state_q == ST_RUN);
    assign requesting = bus.req_read | bus.req_zero | bus.req_write;
    assign arb_en     = run & ~requesting[0];

    usb_rr_arbiter #(.N(NA)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (requesting[N_PORTS-1:1]),
        .en  (arb_en),
        .gnt (arb_gnt)
    );

    assign ready = {arb_gnt, run & requesting[0]};

    // Clear sequence: one zero word per cycle, then run until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // Index of the port granted this cycle (at most one bit of ready is set).
    always_comb begin
        acc_port = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (ready[i]) begin
                acc_port = PW'(i);
            end
        end
    end

    // Stage 1 inputs: capture the granted port's request.
    always_comb begin
        vld_p1_d     = |ready;
        addr_p1_d    = bus.req_addr[int'(acc_port)*AW +: AW];
        din_p1_d     = bus.req_din[int'(acc_port)*DW +: DW];
        op_p1_d      = OP_IDLE;
        op_p1_d.we   = bus.req_write[acc_port];
        op_p1_d.rd   = bus.req_read[acc_port] | bus.req_zero[acc_port];
        op_p1_d.zero = bus.req_zero[acc_port];
        port_p1_d    = acc_port;
    end

    // Single RAM port: the clear sequence owns it until RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_p1_q;
        ram_wdata = din_p1_q;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = '0;
        end else if (vld_p1_q && op_p1_q.we) begin
            ram_we = 1'b1;
        end
    end

    // Stage 2 / 3 inputs: read qualifier and response register update.
    always_comb begin
        vld_p2_d    = vld_p1_q & op_p1_q.rd;
        zero_p2_d   = op_p1_q.zero;
        port_p2_d   = port_p1_q;
        rsp_valid_d = '0;
        rsp_dout_d  = rsp_dout_q;
        if (vld_p2_q) begin
            rsp_valid_d[port_p2_q]               = 1'b1;
            rsp_dout_d[int'(port_p2_q)*DW +: DW] = zero_p2_q ? '0 : data_p2_q;
        end
    end

    // Pipeline control and response registers; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
        end
    end

    // Pipeline data registers; qualified by the valids, so no reset needed.
    always_ff @(posedge clk) begin
        addr_p1_q <= addr_p1_d;
        din_p1_q  <= din_p1_d;
        op_p1_q   <= op_p1_d;
        port_p1_q <= port_p1_d;
        zero_p2_q <= zero_p2_d;
        port_p2_q <= port_p2_d;
    end

    // Status RAM: write-first is not wanted, a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        data_p2_q <= mem[ram_addr];
    end

    assign bus.req_ready = ready;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_usb_ep_status_mp.sv
// Scoreboard bench for usb_ep_status_mp with four ports.
module tb_usb_ep_status_mp;
    localparam int N     = 4;
    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    typedef struct {
        logic          rd;
        logic          zero;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_nxt;

    usb_ep_status_mp_if #(.N_PORTS(N), .AW(AW), .DW(DW)) bus ();

    usb_ep_status_mp #(.N_PORTS(N), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    cmd_t          cmd_q [N][$];
    exp_t          exp_q [N][$];
    cmd_t          cur   [N];
    bit            busy  [N];
    bit            acc   [N];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rsp [N];
    int            gnt_log [$];
    bit            log_en;
    int            cyc;
    int            n_chk;
    int            n_err;
    int            exp_gnt [13] = '{1, 2, 3, 1, 0, 2, 3, 1, 2, 3, 1, 2, 3};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int p, input logic rd, input logic zero, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din);
        cmd_t c;
        c.rd = rd; c.zero = zero; c.wr = wr; c.addr = addr; c.din = din;
        cmd_q[p].push_back(c);
    endtask

    function automatic int pending_cnt();
        int n;
        n = 0;
        for (int p = 0; p < N; p++) begin
            n += cmd_q[p].size() + exp_q[p].size() + int'(busy[p]);
        end
        return n;
    endfunction

    // One clock: drive after the rising edge, observe on the falling edge.
    task automatic step();
        int   nacc;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_nxt;
        for (int p = 0; p < N; p++) begin
            if (busy[p] && acc[p]) busy[p] = 1'b0;
            acc[p] = 1'b0;
            if (!busy[p] && cmd_q[p].size() > 0) begin
                cur[p]  = cmd_q[p].pop_front();
                busy[p] = 1'b1;
            end
            bus.req_read[p]            = busy[p] ? cur[p].rd   : 1'b0;
            bus.req_zero[p]            = busy[p] ? cur[p].zero : 1'b0;
            bus.req_write[p]           = busy[p] ? cur[p].wr   : 1'b0;
            bus.req_addr[p*AW +: AW]   = busy[p] ? cur[p].addr : '0;
            bus.req_din[p*DW +: DW]    = busy[p] ? cur[p].din  : '0;
        end
        @(negedge clk);
        nacc = 0;
        if (!rst) begin
            for (int p = 0; p < N; p++) begin
                if (bus.req_ready[p]) begin
                    nacc++;
                    if (busy[p]) begin
                        acc[p] = 1'b1;
                        if (cur[p].rd || cur[p].zero) begin
                            e.data = cur[p].zero ? '0 : model[cur[p].addr];
                            e.due  = cyc + 3;
                            exp_q[p].push_back(e);
                        end
                        if (cur[p].wr) model[cur[p].addr] = cur[p].din;
                        if (log_en) gnt_log.push_back(p);
                    end else begin
                        chk($sformatf("ready_no_req%0d", p), 64'(bus.req_ready[p]), 64'd0);
                    end
                end
            end
            if (nacc > 1) chk("multi_grant", 64'(nacc), 64'd1);
        end
        for (int p = 0; p < N; p++) begin
            if (bus.rsp_valid[p]) begin
                if (exp_q[p].size() == 0) begin
                    chk($sformatf("rsp_unexpected%0d", p), 64'(bus.rsp_valid[p]), 64'd0);
                end else begin
                    e = exp_q[p].pop_front();
                    chk($sformatf("rsp_data%0d", p), 64'(bus.rsp_dout[p*DW +: DW]), 64'(e.data));
                    chk($sformatf("rsp_lat%0d", p), 64'(cyc), 64'(e.due));
                    last_rsp[p] = e.data;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pending_cnt() != 0 && n < 3000) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(pending_cnt()), 64'd0);
    endtask

    task automatic release_and_clear();
        int bad;
        bad     = 0;
        rst_nxt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (bus.req_ready != '0) bad++;
            if (bus.init_done) bad++;
        end
        chk("clear_quiet", 64'(bad), 64'd0);
        step();
        chk("init_done_rise", 64'(bus.init_done), 64'd1);
    endtask

    task automatic apply_reset();
        rst_nxt = 1'b1;
        step();
        for (int p = 0; p < N; p++) begin
            cmd_q[p].delete();
            exp_q[p].delete();
            busy[p]     = 1'b0;
            acc[p]      = 1'b0;
            last_rsp[p] = '0;
        end
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        repeat (3) step();
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
        chk("rst_dout", 64'(bus.rsp_dout), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic check_hold();
        repeat (3) step();
        for (int p = 0; p < N; p++) begin
            chk($sformatf("dout_hold%0d", p), 64'(bus.rsp_dout[p*DW +: DW]), 64'(last_rsp[p]));
        end
    endtask

    initial begin
        logic [2:0] op;
        n_chk = 0; n_err = 0; cyc = 0; log_en = 1'b0; rst_nxt = 1'b1;
        bus.req_read = '0; bus.req_zero = '0; bus.req_write = '0;
        bus.req_addr = '0; bus.req_din = '0;
        for (int p = 0; p < N; p++) begin
            busy[p] = 1'b0; acc[p] = 1'b0; last_rsp[p] = '0;
        end
        for (int a = 0; a < DEPTH; a++) model[a] = '0;

        // Reset state, then the clear sequence with a read held from the start.
        repeat (3) step();
        chk("rst_valid0", 64'(bus.rsp_valid), 64'd0);
        chk("rst_init0", 64'(bus.init_done), 64'd0);
        chk("rst_dout0", 64'(bus.rsp_dout), 64'd0);
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0);
        release_and_clear();
        chk("first_ready", 64'(bus.req_ready), 64'd1);
        drain();

        // Write then immediate read of the same word on port 0.
        push_cmd(0, 1'b0, 1'b0, 1'b1, 9'h1A5, 16'hBEEF);
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h1A5, 16'h0);
        drain();
        chk("beef_dout", 64'(bus.rsp_dout[15:0]), 64'h0000_0000_0000_BEEF);

        // Round-robin among ports 1..3 with one port-0 request inserted.
        gnt_log.delete();
        log_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int p = 1; p < N; p++) push_cmd(p, 1'b1, 1'b0, 1'b0, AW'(16 * p + k), 16'h0);
        end
        repeat (4) step();
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h1A5, 16'h0);
        drain();
        log_en = 1'b0;
        chk("arb_len", 64'(gnt_log.size()), 64'd13);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("arb_seq%0d", i), (i < gnt_log.size()) ? 64'(gnt_log[i]) : 64'hFFFF,
                64'(exp_gnt[i]));
        end

        // Zero-read leaves the stored word intact.
        push_cmd(1, 1'b0, 1'b0, 1'b1, 9'h020, 16'h1234);
        push_cmd(1, 1'b0, 1'b1, 1'b0, 9'h020, 16'h0);
        push_cmd(1, 1'b1, 1'b0, 1'b0, 9'h020, 16'h0);
        drain();
        chk("zero_then_read", 64'(bus.rsp_dout[1*DW +: DW]), 64'h1234);

        // Combined write+read returns the old word.
        push_cmd(2, 1'b0, 1'b0, 1'b1, 9'h010, 16'h5555);
        drain();
        push_cmd(1, 1'b1, 1'b0, 1'b1, 9'h010, 16'hAAAA);
        push_cmd(1, 1'b1, 1'b0, 1'b0, 9'h010, 16'h0);
        drain();
        chk("rw_new", 64'(bus.rsp_dout[1*DW +: DW]), 64'hAAAA);

        // Zero+write: response 0, word updated.
        push_cmd(3, 1'b0, 1'b1, 1'b1, 9'h030, 16'h7777);
        push_cmd(3, 1'b1, 1'b0, 1'b0, 9'h030, 16'h0);
        drain();
        check_hold();

        // Random mixed traffic on all ports over a small address window.
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < 25; k++) begin
                op = 3'($urandom_range(1, 7));
                push_cmd(p, op[0], op[1], op[2], AW'(9'h040 + $urandom_range(0, 7)),
                         DW'($urandom));
            end
        end
        drain();
        check_hold();

        // Reset with reads in flight: no responses, clear restarts, memory is zero.
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h1A5, 16'h0);
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h010, 16'h0);
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h030, 16'h0);
        step();
        step();
        apply_reset();
        release_and_clear();
        push_cmd(0, 1'b1, 1'b0, 1'b0, 9'h1A5, 16'h0);
        push_cmd(1, 1'b1, 1'b0, 1'b0, 9'h010, 16'h0);
        push_cmd(2, 1'b1, 1'b0, 1'b0, 9'h030, 16'h0);
        push_cmd(3, 1'b1, 1'b0, 1'b0, 9'h020, 16'h0);
        for (int k = 0; k < 8; k++) push_cmd(1 + (k % 3), 1'b1, 1'b0, 1'b0, AW'(9'h040 + k), 16'h0);
        drain();
        check_hold();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/usb_ep_status_mp.md
Name: usb_ep_status_mp

Overview:
Parametrised multi-port front-end plus storage for USB endpoint status/descriptor words. Generalises the two-port EP status block to N_PORTS requesters:
- port 0 has absolute priority (USB protocol engine);
- ports 1..N_PORTS-1 are round-robin arbitrated (bus bridge, DMA, debug).

Adds an automatic post-reset clear sequence, so status memory is defined (all zero) before first use. Sits between the USB transaction engine/CSR bridge and an inferred single-port synchronous RAM.

Parameters:
N_PORTS, 2, number of requester ports (2..8)
AW, 9, word address width; DEPTH = 2**AW words
DW, 16, data word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_addr  in  N_PORTS*AW  per-port word address, port i at [i*AW +: AW]
req_read  in  N_PORTS  per-port read request
req_zero  in  N_PORTS  per-port read returning zero (slot still consumed)
req_write  in  N_PORTS  per-port write request
req_din  in  N_PORTS*DW  per-port write data
req_ready  out  N_PORTS  request accepted this cycle
rsp_dout  out  N_PORTS*DW  per-port read data register
rsp_valid  out  N_PORTS  one-cycle pulse: rsp_dout[i] updated
init_done  out  1  high once the post-reset clear has completed

Behaviour:
- Reset: rsp_dout=0, rsp_valid=0, init_done=0, all pipeline valids cleared, RR pointer=port 1 highest, FSM->CLEAR, clear counter=0. Reset asserted mid-clear or mid-operation restarts the clear; in-flight requests are dropped with no rsp_valid.
- FSM CLEAR:
  - writes 0 to word clr_cnt each cycle; clr_cnt increments.
  - after word DEPTH-1 is written: ->RUN and init_done=1 next cycle. CLEAR lasts exactly DEPTH cycles.
  - req_ready=0 on all ports during CLEAR.
- FSM RUN: permanent until rst.
- A port is requesting when read|zero|write is high. Requesters hold their request until req_ready.
- Arbitration (combinational, RUN only):
  - req_ready[0] = port 0 requesting.
  - Port i>0 is granted only if port 0 is idle and i wins round-robin among requesting ports 1..N-1, searching from (last granted + 1) with wrap.
  - RR pointer updates only when a port >0 is granted.
  - At most one grant per cycle.
- Pipeline, with T = the accept cycle:
  - Stage 1 (edge ending T): register addr, din, we=write, rd=read|zero, zero, port index.
  - Stage 2 (next edge): RAM performs the write if we, and reads addr into the data register (read-during-write returns OLD data).
  - Stage 3 (next edge): if rd, rsp_dout[port] <= zero ? 0 : data, and rsp_valid[port]=1 for one cycle.
  - Read latency: rsp_valid is high in cycle T+3.
  - Write-only requests produce no rsp_valid.
- Back-to-back: a write accepted at T followed by a read of the same address at T+1 returns the new data. No forwarding is needed, since the write lands before the read's RAM access.
- zero+write in one request: word is written, response is 0.
- Throughput: one request per cycle sustained.
- rsp_dout[i] holds its value until the next read response to port i.

Decomposition:
- Shared header: op encoding constants, clog2 helper for the port index width.
- Sub-module usb_rr_arbiter (parametrised N, request vector in, one-hot grant out, pointer update on enable) for ports 1..N-1.
- RAM inferred in place.

Test Plan:
- Reset then idle -> req_ready=0 for 512 cycles (AW=9); init_done rises on cycle 513; read of addr 0x1FF returns 0x0000 at T+3.
- Port0 write 0x1A5=0xBEEF at T, port0 read 0x1A5 at T+1 -> rsp_valid[0] at T+4, rsp_dout[0]=0xBEEF.
- N_PORTS=4: ports 1,2,3 continuously reading -> grants cycle 1,2,3,1,...; port0 request inserted -> port0 granted that cycle, RR order resumes unchanged.
- Port1 zero-read of a word holding 0x1234 -> rsp_dout[1]=0x0000 with rsp_valid pulse; word still reads 0x1234 afterwards.
- Port1 write+read 0x010 (old 0x5555, new 0xAAAA) -> response 0x5555; a subsequent read returns 0xAAAA.
- rst asserted mid-RUN with 3 reads in flight -> no rsp_valid pulses; CLEAR restarts; all words read 0 afterwards.
